// File: rtl/pad_sensor_conditioner.sv
// rtl/pad_sensor_conditioner.sv - pad sensor thresholding, debounce and hit-event capture
// Per-pad hysteresis FSM with debounce counter feeding a single-entry valid/ack event register.
module pad_sensor_conditioner #(
  parameter int          NUM_PADS     = 3,
  parameter logic [7:0]  THRESH_ON    = 8'd160,
  parameter logic [7:0]  THRESH_OFF   = 8'd96,
  parameter int          DEBOUNCE_CYC = 50000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [31:0]         sensor_input,
  input  logic                enable,
  output logic [NUM_PADS-1:0] pad_state,
  output logic [NUM_PADS-1:0] hit_pulse,
  output logic                hit_valid,
  output logic [1:0]          hit_pad,
  output logic [7:0]          hit_peak,
  input  logic                hit_ack,
  output logic                hit_overflow
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_PRESSED = 2'd2,
    ST_REL     = 2'd3
  } pad_fsm_e;

  logic [8*NUM_PADS-1:0] r_s1, r_s2;
  pad_fsm_e              r_st       [NUM_PADS];
  pad_fsm_e              w_st_nxt   [NUM_PADS];
  logic [15:0]           r_cnt      [NUM_PADS];
  logic [15:0]           w_cnt_nxt  [NUM_PADS];
  logic [7:0]            r_peak     [NUM_PADS];
  logic [7:0]            w_peak_nxt [NUM_PADS];
  logic [7:0]            w_x        [NUM_PADS];
  logic [NUM_PADS-1:0]   w_fire;
  logic [NUM_PADS-1:0]   r_hit_pulse;

  logic                  w_offer, w_extra;
  logic [1:0]            w_sel_pad;
  logic [7:0]            w_sel_peak;
  logic                  r_hit_valid, r_hit_overflow;
  logic [1:0]            r_hit_pad;
  logic [7:0]            r_hit_peak;
  logic                  w_unused;

  assign w_unused = ^sensor_input[31:8*NUM_PADS];

  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      w_x[i]        = r_s2[8*i +: 8];
      w_st_nxt[i]   = r_st[i];
      w_cnt_nxt[i]  = r_cnt[i];
      w_peak_nxt[i] = r_peak[i];
      w_fire[i]     = 1'b0;
      if (!enable) begin
        w_st_nxt[i]   = ST_IDLE;
        w_cnt_nxt[i]  = 16'd0;
        w_peak_nxt[i] = 8'd0;
      end else begin
        unique case (r_st[i])
          ST_IDLE: if (w_x[i] >= THRESH_ON) begin
            w_st_nxt[i]   = ST_ARM;
            w_cnt_nxt[i]  = 16'd1;
            w_peak_nxt[i] = w_x[i];
          end
          ST_ARM: if (w_x[i] < THRESH_ON) begin
            w_st_nxt[i] = ST_IDLE;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_st_nxt[i] = ST_PRESSED;
            w_fire[i]   = 1'b1;
          end else begin
            w_cnt_nxt[i]  = r_cnt[i] + 16'd1;
            w_peak_nxt[i] = (w_x[i] > r_peak[i]) ? w_x[i] : r_peak[i];
          end
          ST_PRESSED: if (w_x[i] <= THRESH_OFF) begin
            w_st_nxt[i]  = ST_REL;
            w_cnt_nxt[i] = 16'd1;
          end
          ST_REL: if (w_x[i] > THRESH_OFF) begin
            w_st_nxt[i] = ST_PRESSED;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_st_nxt[i] = ST_IDLE;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 16'd1;
          end
          default: w_st_nxt[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_hit_pulse <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        r_st[i]   <= ST_IDLE;
        r_cnt[i]  <= 16'd0;
        r_peak[i] <= 8'd0;
      end
    end else begin
      r_s1        <= sensor_input[8*NUM_PADS-1:0];
      r_s2        <= r_s1;
      r_hit_pulse <= w_fire;
      for (int i = 0; i < NUM_PADS; i++) begin
        r_st[i]   <= w_st_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
        r_peak[i] <= w_peak_nxt[i];
      end
    end
  end

  // Lowest firing pad is offered; any further simultaneous fire is a drop.
  always_comb begin
    w_offer    = 1'b0;
    w_extra    = 1'b0;
    w_sel_pad  = 2'd0;
    w_sel_peak = 8'd0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (w_fire[i]) begin
        if (!w_offer) begin
          w_offer    = 1'b1;
          w_sel_pad  = 2'(i);
          w_sel_peak = r_peak[i];
        end else begin
          w_extra = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_hit_valid    <= 1'b0;
      r_hit_pad      <= 2'd0;
      r_hit_peak     <= 8'd0;
      r_hit_overflow <= 1'b0;
    end else begin
      if (w_offer && (!r_hit_valid || hit_ack)) begin
        r_hit_valid <= 1'b1;
        r_hit_pad   <= w_sel_pad;
        r_hit_peak  <= w_sel_peak;
      end else if (hit_ack && r_hit_valid) begin
        r_hit_valid <= 1'b0;
      end
      if (w_extra || (w_offer && r_hit_valid && !hit_ack)) begin
        r_hit_overflow <= 1'b1;
      end else if (hit_ack && r_hit_valid && !w_offer) begin
        r_hit_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_state[i] = (r_st[i] == ST_PRESSED) || (r_st[i] == ST_REL);
    end
  end

  assign hit_pulse    = r_hit_pulse;
  assign hit_valid    = r_hit_valid;
  assign hit_pad      = r_hit_pad;
  assign hit_peak     = r_hit_peak;
  assign hit_overflow = r_hit_overflow;

endmodule
